out_pea_cfg_seq: RTL

OUT_PEA_CFG_SEQ -- requirements
Module: out_pea_cfg_seq

---
 rtl/out_pea_cfg_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/out_pea_cfg_seq.sv
// out_pea_cfg_seq: steps the PEA output selectors through the configuration banks.
//
// After a start request the block presents the selectors of banks 0..last_bank once per
// cycle, and repeats that sweep n_iter times. stall_i freezes the sequence. A one-cycle
// done_o pulse marks the end of the run.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   reg_cfg_sel_out_pea_i  all banks' selectors; bank b, output j at (b*N_OUT_PEA+j)*LOG_M
//   last_bank_i            last bank of each sweep (captured at start, clamped)
//   n_iter_i               number of sweeps (captured at start; 0 gives an empty run)
//   start_i                single-cycle start request, honoured only when idle
//   stall_i                back-pressure; holds the presented bank
//   sel_output_o           registered selectors of the presented bank
//   bank_idx_o             index of the presented bank
//   valid_o, busy_o        selectors valid / run in progress
//   done_o                 one-cycle completion pulse
//
// Build option: define OUT_PEA_SEQ_SHADOW_EN to snapshot the configuration at start and
// run from that copy; otherwise selectors are read from the live configuration input.
module out_pea_cfg_seq #(
    parameter int unsigned N_OUT_PEA     = 8,
    parameter int unsigned LOG_M         = 4,
    parameter int unsigned CFG_BANK_SIZE = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [CFG_BANK_SIZE*N_OUT_PEA*LOG_M-1:0]   reg_cfg_sel_out_pea_i,
    input  logic [$clog2(CFG_BANK_SIZE)-1:0]           last_bank_i,
    input  logic [15:0]                                n_iter_i,
    input  logic                                       start_i,
    input  logic                                       stall_i,
    output logic [N_OUT_PEA*LOG_M-1:0]                 sel_output_o,
    output logic [$clog2(CFG_BANK_SIZE)-1:0]           bank_idx_o,
    output logic                                       valid_o,
    output logic                                       busy_o,
    output logic                                       done_o
);

    localparam int unsigned SEL_W  = N_OUT_PEA * LOG_M;
    localparam int unsigned CFG_W  = CFG_BANK_SIZE * SEL_W;
    localparam int unsigned BANK_W = $clog2(CFG_BANK_SIZE);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q;
    logic [BANK_W-1:0]   last_bank_q;
    logic [15:0]         n_iter_q;
    logic [15:0]         iter_q;
    logic [BANK_W-1:0]   last_bank_clamped;
    logic [BANK_W-1:0]   bank_inc;
    logic [CFG_W-1:0]    cfg_src;
    logic [SEL_W-1:0]    bank_sel [CFG_BANK_SIZE];

    // A power-of-two bank count cannot be exceeded by the index width, so no clamp is needed.
    if (CFG_BANK_SIZE == (1 << BANK_W)) begin : g_no_clamp
        assign last_bank_clamped = last_bank_i;
    end else begin : g_clamp
        localparam logic [BANK_W-1:0] MaxBank = BANK_W'(CFG_BANK_SIZE - 1);
        assign last_bank_clamped = (last_bank_i > MaxBank) ? MaxBank : last_bank_i;
    end

`ifdef OUT_PEA_SEQ_SHADOW_EN
    logic [CFG_W-1:0] shadow_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
        end else if (state_q == StIdle && start_i) begin
            shadow_q <= reg_cfg_sel_out_pea_i;
        end
    end

    // Bank 0 is loaded on the start edge itself, before the snapshot exists.
    assign cfg_src = (state_q == StIdle) ? reg_cfg_sel_out_pea_i : shadow_q;
`else
    assign cfg_src = reg_cfg_sel_out_pea_i;
`endif

    always_comb begin
        for (int b = 0; b < CFG_BANK_SIZE; b++) begin
            bank_sel[b] = cfg_src[b*SEL_W +: SEL_W];
        end
    end

    assign bank_inc = bank_idx_o + BANK_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_bank_q  <= '0;
            n_iter_q     <= '0;
            iter_q       <= '0;
            sel_output_o <= '0;
            bank_idx_o   <= '0;
            valid_o      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        last_bank_q <= last_bank_clamped;
                        n_iter_q    <= n_iter_i;
                        iter_q      <= '0;
                        if (n_iter_i != 16'd0) begin
                            state_q      <= StRun;
                            sel_output_o <= bank_sel[0];
                            bank_idx_o   <= '0;
                            valid_o      <= 1'b1;
                            busy_o       <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done_o  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (!stall_i) begin
                        if (bank_idx_o == last_bank_q) begin
                            if (iter_q == n_iter_q - 16'd1) begin
                                state_q <= StDone;
                                valid_o <= 1'b0;
                                busy_o  <= 1'b0;
                                done_o  <= 1'b1;
                            end else begin
                                iter_q       <= iter_q + 16'd1;
                                bank_idx_o   <= '0;
                                sel_output_o <= bank_sel[0];
                            end
                        end else begin
                            bank_idx_o   <= bank_inc;
                            sel_output_o <= bank_sel[bank_inc];
                        end
                    end
                end
                StDone: begin
                    done_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
